// File: rtl/alu_core.sv
// alu_core: single-cycle RV32 integer ALU with registered result and zero flag.
//
// Ports
//   i_clk    : rising-edge clock
//   i_rst    : synchronous active-high reset (wins over i_valid)
//   i_valid  : i_op / i_Ra / i_Rb are valid this cycle
//   i_op     : operation select (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB, SRA)
//   i_Ra     : operand A
//   i_Rb     : operand B; shifts use i_Rb[4:0] only
//   o_valid  : one-cycle pulse, o_Rc/o_Z carry a new result
//   o_Rc     : result; bit DATA_W is carry/borrow/shift-out, low DATA_W bits the result
//   o_Z      : 1 when o_Rc[DATA_W-1:0] is zero (bit DATA_W ignored)
//
// Build option
//   ALU_CARRY_OUT_EN : when defined, o_Rc[DATA_W] reports carry/borrow/shift-out.
//                      When undefined, o_Rc[DATA_W] is tied to 0 and no
//                      extended-width arithmetic is built.
module alu_core #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_Ra,
    input  logic [DATA_W-1:0] i_Rb,
    output logic              o_valid,
    output logic [DATA_W:0]   o_Rc,
    output logic              o_Z
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned RES_W   = DATA_W + 1;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;

    logic [SHAMT_W-1:0] shamt_c;
    logic [RES_W-1:0]   res_c;
    logic               zero_c;

    assign shamt_c = i_Rb[SHAMT_W-1:0];

    // Result datapath; unlisted opcodes fall through to zero.
    always_comb begin
        res_c = '0;
        case (i_op)
`ifdef ALU_CARRY_OUT_EN
            OP_ADD:  res_c = {1'b0, i_Ra} + {1'b0, i_Rb};
            OP_SUB:  res_c = {1'b0, i_Ra} - {1'b0, i_Rb};
            // 33-bit shift leaves the last bit pushed out of bit 31 in bit 32
            OP_SLL:  res_c = {1'b0, i_Ra} << shamt_c;
`else
            OP_ADD:  res_c = {1'b0, i_Ra + i_Rb};
            OP_SUB:  res_c = {1'b0, i_Ra - i_Rb};
            OP_SLL:  res_c = {1'b0, i_Ra << shamt_c};
`endif
            OP_SLT:  res_c = RES_W'($signed(i_Ra) < $signed(i_Rb));
            OP_SLTU: res_c = RES_W'(i_Ra < i_Rb);
            OP_XOR:  res_c = {1'b0, i_Ra ^ i_Rb};
            OP_SRL:  res_c = {1'b0, i_Ra >> shamt_c};
            OP_OR:   res_c = {1'b0, i_Ra | i_Rb};
            OP_AND:  res_c = {1'b0, i_Ra & i_Rb};
            OP_SRA:  res_c = {1'b0, DATA_W'($signed(i_Ra) >>> shamt_c)};
            default: res_c = '0;
        endcase
    end

    assign zero_c = (res_c[DATA_W-1:0] == '0);

    // Output registers: results only load on i_valid, otherwise they hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_Rc    <= '0;
            o_Z     <= 1'b1;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_Rc <= res_c;
                o_Z  <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [3:0]  i_op;
    logic [31:0] i_Ra;
    logic [31:0] i_Rb;
    logic        o_valid;
    logic [32:0] o_Rc;
    logic        o_Z;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef ALU_CARRY_OUT_EN
    localparam bit CO = 1'b1;
`else
    localparam bit CO = 1'b0;
`endif

    alu_core #(.DATA_W(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_Ra    (i_Ra),
        .i_Rb    (i_Rb),
        .o_valid (o_valid),
        .o_Rc    (o_Rc),
        .o_Z     (o_Z)
    );

    always #5 i_clk = ~i_clk;

    // Reference ALU computed with wide integer arithmetic.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned r;
        longint          sa;
        int              sh;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sh = int'(b[4:0]);
        case (op)
            4'd0:  r = ua + ub;
            4'd8:  r = ua + 64'h2_0000_0000 - ub;
            4'd2:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd3:  r = (ua < ub) ? 64'd1 : 64'd0;
            4'd1:  r = ua << sh;
            4'd5:  r = ua >> sh;
            4'd13: r = 64'(sa >>> sh) & 64'hFFFF_FFFF;
            4'd4:  r = ua ^ ub;
            4'd6:  r = ua | ub;
            4'd7:  r = ua & ub;
            default: r = 64'd0;
        endcase
        r = r & 64'h1_FFFF_FFFF;
        if (!CO) r = r & 64'hFFFF_FFFF;
        return r[32:0];
    endfunction

    logic [32:0] ref_now;
    always_comb ref_now = ref_alu(i_op, i_Ra, i_Rb);

    // Expected output register state.
    logic        exp_valid;
    logic [32:0] exp_rc;
    logic        exp_z;

    always @(posedge i_clk) begin
        if (i_rst) begin
            exp_valid <= 1'b0;
            exp_rc    <= '0;
            exp_z     <= 1'b1;
        end else begin
            exp_valid <= i_valid;
            if (i_valid) begin
                exp_rc <= ref_now;
                exp_z  <= (ref_now[31:0] == 32'd0);
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            checks++;
            if (o_valid !== exp_valid || o_Rc !== exp_rc || o_Z !== exp_z) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got v=%0b rc=%h z=%0b expected v=%0b rc=%h z=%0b",
                         $time, o_valid, o_Rc, o_Z, exp_valid, exp_rc, exp_z);
            end
            checks++;
            if (o_Z !== (o_Rc[31:0] == 32'd0)) begin
                errors++;
                $display("FAIL z_consistency t=%0t: got z=%0b rc=%h", $time, o_Z, o_Rc);
            end
        end
    end

    // Issue one op (called at posedge+1) and check the literal result one cycle later.
    task automatic op_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [32:0] er, input logic ez);
        i_valid = 1'b1;
        i_op    = op;
        i_Ra    = a;
        i_Rb    = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_Rc !== er || o_Z !== ez) begin
            errors++;
            $display("FAIL %s: got v=%0b rc=%h z=%0b expected v=1 rc=%h z=%0b",
                     name, o_valid, o_Rc, o_Z, er, ez);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (o_valid !== 1'b0 || o_Rc !== 33'd0 || o_Z !== 1'b1) begin
            errors++;
            $display("FAIL %s: got v=%0b rc=%h z=%0b expected v=0 rc=0 z=1",
                     name, o_valid, o_Rc, o_Z);
        end
    endtask

    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13};

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_op    = 4'd0;
        i_Ra    = 32'd0;
        i_Rb    = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_en = 1'b1;
        check_reset_state("reset_state");
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        op_lit("add_carry",  4'd0,  32'hFFFF_FFFF, 32'd1,         {CO, 32'h0000_0000}, 1'b1);
        op_lit("sub_borrow", 4'd8,  32'd5,         32'd7,         {CO, 32'hFFFF_FFFE}, 1'b0);
        op_lit("sub_equal",  4'd8,  32'h1234,      32'h1234,      33'd0,               1'b1);
        op_lit("slt_neg",    4'd2,  32'h8000_0000, 32'd1,         33'd1,               1'b0);
        op_lit("sltu_big",   4'd3,  32'h8000_0000, 32'd1,         33'd0,               1'b1);
        op_lit("sra_fill",   4'd13, 32'h8000_0000, 32'h24,        33'h0_F800_0000,     1'b0);
        op_lit("srl_fill",   4'd5,  32'h8000_0000, 32'h24,        33'h0_0800_0000,     1'b0);
        op_lit("sll_out",    4'd1,  32'hC000_0001, 32'd1,         {CO, 32'h8000_0002}, 1'b0);
        op_lit("sll_sh0",    4'd1,  32'hC000_0001, 32'hFFFF_FFE0, 33'h0_C000_0001,     1'b0);
        op_lit("unlisted",   4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 33'd0,               1'b1);
        op_lit("xor_self",   4'd4,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 33'd0,               1'b1);
        op_lit("or_bits",    4'd6,  32'hF0F0_0000, 32'h0000_0F0F, 33'h0_F0F0_0F0F,     1'b0);

        // Idle cycles: outputs must hold the last result with o_valid low.
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_Rc !== 33'h0_F0F0_0F0F || o_Z !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got v=%0b rc=%h z=%0b expected v=0 rc=0f0f00f0f z=0",
                     o_valid, o_Rc, o_Z);
        end

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                i_rst   = 1'b1;
                i_valid = 1'b1;
                i_op    = 4'd0;
                i_Ra    = 32'hFFFF_FFFF;
                i_Rb    = 32'd5;
                @(posedge i_clk);
                #1;
                check_reset_state("reset_midstream");
                i_rst = 1'b0;
                op_lit("first_after_reset", 4'd0, 32'hFFFF_FFFF, 32'd5, {CO, 32'h0000_0004}, 1'b0);
            end
            i_valid = (i < 1000) ? 1'b1 : ($urandom_range(0, 9) != 0);
            i_op    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                  : ops[$urandom_range(0, 9)];
            i_Ra    = $urandom;
            case ($urandom_range(0, 3))
                0:       i_Rb = i_Ra;
                1:       i_Rb = 32'($urandom_range(0, 31));
                2:       i_Rb = ~i_Ra;
                default: i_Rb = $urandom;
            endcase
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
